tlb_op_ctrl: RTL and testbench
==============================

Name: tlb_op_ctrl

Overview:
- Sequences the TLB maintenance instructions TLBP, TLBR, TLBWI and TLBWR from the memory stage against the TLB array.
- Arbitrates the single TLB search port between this sequencer and data-side address translation.
- Owns the Random register.
- Sits between the M-stage decode, cp0 (which consumes tlb_type_o and index_wdata_o) and the TLB array.

Parameters:
- TLB_ENTRIES, 16, number of TLB entries; power of two, 2..32.
- IDX_W, 4, index width; must equal log2(TLB_ENTRIES).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous reset, active-low.
- op_valid_i  in  1  M-stage holds a TLB op.
- op_type_i  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
- flush_i  in  1  pipeline flush (exception/eret).
- cp0_index_i  in  32  current CP0 Index.
- stall_o  out  1  stall request to pipeline.
- op_done_o  out  1  one-cycle completion pulse.
- dtlb_req_i  in  1  data side requests the search port.
- dtlb_gnt_o  out  1  data side owns the search port this cycle.
- tlb_search_o  out  1  sequencer drives the search port (search key is EntryHi).
- tlb_match_i  in  1  search hit.
- tlb_match_idx_i  in  IDX_W  hit index.
- tlb_ridx_o  out  IDX_W  read index.
- tlb_we_o  out  1  TLB write strobe.
- tlb_widx_o  out  IDX_W  write index.
- tlb_type_o  out  2  to cp0: 01 load PageMask/EntryHi/EntryLo0/EntryLo1 from TLB read, 10 load Index, 00 none.
- index_wdata_o  out  32  value cp0 loads into Index when tlb_type_o=10.
- random_o  out  IDX_W  Random register.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE; random_o=TLB_ENTRIES-1; all other outputs 0.
- States: IDLE, SEARCH, READ, WRITE, DONE.
- Random register:
  - Decrements every cycle and wraps 0 -> TLB_ENTRIES-1.
  - Never stalls.
- IDLE:
  - Accepts when op_valid_i=1 and flush_i=0.
  - On accept, latches op type, cp0_index_i[IDX_W-1:0] and random_o (for TLBWR).
  - Next state: TLBP -> SEARCH, TLBR -> READ, TLBWI/TLBWR -> WRITE.
  - dtlb_gnt_o = dtlb_req_i in IDLE and DONE.
- SEARCH:
  - tlb_search_o=1 and dtlb_gnt_o=0 (the sequencer wins the port; the data side waits).
  - Latches tlb_match_i and tlb_match_idx_i, then goes to DONE.
- READ:
  - tlb_ridx_o = latched index (held valid in READ and DONE), then goes to DONE.
- WRITE:
  - tlb_we_o = ~flush_i for exactly one cycle.
  - tlb_widx_o = latched Index for TLBWI, latched random for TLBWR.
  - Goes to DONE.
- DONE:
  - op_done_o=1 for one cycle.
  - TLBP: tlb_type_o=10; index_wdata_o = hit ? {27'b0, idx zero-extended} : 32'h8000_0000 (P bit set, index field 0).
  - TLBR: tlb_type_o=01.
  - TLBWI/TLBWR: tlb_type_o=00.
  - Returns to IDLE. No back-to-back accept from DONE; at least one IDLE cycle separates ops.
- stall_o = (IDLE & op_valid_i & ~flush_i) | SEARCH | READ | WRITE. It is low in DONE, so the M stage advances exactly when op_done_o fires.
- Latency: every op spends 3 cycles from accept to op_done_o (accept, SEARCH/READ/WRITE, DONE).
- Flush:
  - flush_i in SEARCH, READ or WRITE aborts to IDLE next cycle: no tlb_we_o, no op_done_o, tlb_type_o stays 00.
  - flush_i in DONE does not cancel the writeback.
- op_valid_i dropping mid-operation is ignored; latched values are used.
- tlb_type_o and index_wdata_o are 0 outside DONE.

Optional Feature:
- Macro TLB_OP_PERF_CNT_EN.
- Defined: adds output perf_ops_o[31:0] and perf_miss_o[31:0], both reset to 0 by resetn.
  - perf_ops_o increments on each op_done_o.
  - perf_miss_o increments on each TLBP DONE with no hit.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent. Benches guard any checks on them with the same macro.

Test Plan:
- Reset release -> random_o=15, then 14, 13, ..., 0, 15 on successive cycles; all other outputs 0.
- TLBP with tlb_match_i=1 and tlb_match_idx_i=5 in SEARCH -> DONE shows tlb_type_o=10, index_wdata_o=32'h0000_0005; stall_o high for 2 cycles; op_done_o 1 cycle.
- TLBP with no hit, dtlb_req_i=1 throughout -> dtlb_gnt_o=0 only in SEARCH; index_wdata_o=32'h8000_0000.
- TLBWI with cp0_index_i=7 -> one tlb_we_o pulse with tlb_widx_o=7. TLBWR accepted when random_o=3 -> tlb_widx_o=3.
- TLBR with cp0_index_i=9 -> tlb_ridx_o=9 in READ and DONE; tlb_type_o=01 in DONE only.
- flush_i asserted in WRITE -> tlb_we_o=0, no op_done_o, IDLE next cycle. resetn dropped mid-SEARCH -> immediate IDLE with outputs cleared.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBP/TLBR/TLBWI/TLBWR, arbitrates the TLB search port, owns Random.
// Optional perf counters enabled by defining TLB_OP_PERF_CNT_EN.
module tlb_op_ctrl #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid_i,
  input  logic [1:0]       op_type_i,
  input  logic             flush_i,
  input  logic [31:0]      cp0_index_i,
  output logic             stall_o,
  output logic             op_done_o,
  input  logic             dtlb_req_i,
  output logic             dtlb_gnt_o,
  output logic             tlb_search_o,
  input  logic             tlb_match_i,
  input  logic [IDX_W-1:0] tlb_match_idx_i,
  output logic [IDX_W-1:0] tlb_ridx_o,
  output logic             tlb_we_o,
  output logic [IDX_W-1:0] tlb_widx_o,
  output logic [1:0]       tlb_type_o,
  output logic [31:0]      index_wdata_o,
`ifdef TLB_OP_PERF_CNT_EN
  output logic [31:0]      perf_ops_o,
  output logic [31:0]      perf_miss_o,
`endif
  output logic [IDX_W-1:0] random_o
);
  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_READ, S_WRITE, S_DONE} state_t;
  localparam logic [1:0] OP_P = 2'b00, OP_R = 2'b01, OP_WR = 2'b11;
  state_t           r_state;
  logic [1:0]       r_op;
  logic [IDX_W-1:0] r_idx, r_rand, r_hidx, r_random;
  logic             r_hit;
  logic             w_accept, w_busy, w_done;
  logic             w_unused;
  assign w_unused = ^cp0_index_i[31:IDX_W];
  assign w_accept = (r_state == S_IDLE) & op_valid_i & ~flush_i;
  assign w_busy   = (r_state == S_SEARCH) | (r_state == S_READ) | (r_state == S_WRITE);
  assign w_done   = r_state == S_DONE;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_idx    <= '0;
      r_rand   <= '0;
      r_hidx   <= '0;
      r_hit    <= 1'b0;
      r_random <= IDX_W'(TLB_ENTRIES - 1);
    end else begin
      r_random <= (r_random == '0) ? IDX_W'(TLB_ENTRIES - 1) : r_random - 1'b1;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= op_type_i;
          r_idx   <= cp0_index_i[IDX_W-1:0];
          r_rand  <= r_random;
          r_state <= (op_type_i == OP_P) ? S_SEARCH : (op_type_i == OP_R) ? S_READ : S_WRITE;
        end
        S_SEARCH: begin
          r_hit   <= tlb_match_i;
          r_hidx  <= tlb_match_idx_i;
          r_state <= flush_i ? S_IDLE : S_DONE;
        end
        S_READ, S_WRITE: r_state <= flush_i ? S_IDLE : S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign random_o      = r_random;
  assign stall_o       = w_accept | w_busy;
  assign op_done_o     = w_done;
  assign tlb_search_o  = r_state == S_SEARCH;
  assign dtlb_gnt_o    = dtlb_req_i & ((r_state == S_IDLE) | w_done);
  assign tlb_ridx_o    = ((r_state == S_READ) | w_done) ? r_idx : '0;
  assign tlb_we_o      = (r_state == S_WRITE) & ~flush_i;
  assign tlb_widx_o    = (r_state == S_WRITE) ? ((r_op == OP_WR) ? r_rand : r_idx) : '0;
  assign tlb_type_o    = !w_done ? 2'b00 : (r_op == OP_P) ? 2'b10 : (r_op == OP_R) ? 2'b01 : 2'b00;
  // A TLBP miss reports the probe-failure bit with a zero index field.
  assign index_wdata_o = (w_done && r_op == OP_P) ? (r_hit ? {{(32-IDX_W){1'b0}}, r_hidx} : 32'h8000_0000) : '0;
`ifdef TLB_OP_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_ops_o  <= '0;
      perf_miss_o <= '0;
    end else if (w_done) begin
      perf_ops_o  <= perf_ops_o + 1'b1;
      perf_miss_o <= perf_miss_o + {31'b0, (r_op == OP_P) & ~r_hit};
    end
  end
`endif
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed immediate-assertion bench for tlb_op_ctrl.
module tb_tlb_op_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid_i, flush_i, dtlb_req_i, tlb_match_i;
  logic [1:0]  op_type_i;
  logic [31:0] cp0_index_i;
  logic [3:0]  tlb_match_idx_i;
  logic        stall_o, op_done_o, dtlb_gnt_o, tlb_search_o, tlb_we_o;
  logic [3:0]  tlb_ridx_o, tlb_widx_o, random_o;
  logic [1:0]  tlb_type_o;
  logic [31:0] index_wdata_o;
`ifdef TLB_OP_PERF_CNT_EN
  logic [31:0] perf_ops_o, perf_miss_o;
`endif
  int          n_assert = 0;
  int          n_fail = 0;
  int          exp_rand = 15;

  tlb_op_ctrl #(.TLB_ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .resetn(resetn), .op_valid_i(op_valid_i), .op_type_i(op_type_i),
    .flush_i(flush_i), .cp0_index_i(cp0_index_i), .stall_o(stall_o), .op_done_o(op_done_o),
    .dtlb_req_i(dtlb_req_i), .dtlb_gnt_o(dtlb_gnt_o), .tlb_search_o(tlb_search_o),
    .tlb_match_i(tlb_match_i), .tlb_match_idx_i(tlb_match_idx_i), .tlb_ridx_o(tlb_ridx_o),
    .tlb_we_o(tlb_we_o), .tlb_widx_o(tlb_widx_o), .tlb_type_o(tlb_type_o),
    .index_wdata_o(index_wdata_o),
`ifdef TLB_OP_PERF_CNT_EN
    .perf_ops_o(perf_ops_o), .perf_miss_o(perf_miss_o),
`endif
    .random_o(random_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; Random follows its own model and is checked every cycle.
  task automatic tick();
    @(posedge clk);
    if (resetn) exp_rand = (exp_rand + 15) % 16;
    #1;
    chk("random", {28'b0, random_o}, exp_rand[31:0]);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, {31'b0, stall_o}, 0);
    chk({tag, "_done"}, {31'b0, op_done_o}, 0);
    chk({tag, "_search"}, {31'b0, tlb_search_o}, 0);
    chk({tag, "_we"}, {31'b0, tlb_we_o}, 0);
    chk({tag, "_type"}, {30'b0, tlb_type_o}, 0);
    chk({tag, "_wdata"}, index_wdata_o, 0);
    chk({tag, "_ridx"}, {28'b0, tlb_ridx_o}, 0);
    chk({tag, "_widx"}, {28'b0, tlb_widx_o}, 0);
    chk({tag, "_gnt"}, {31'b0, dtlb_gnt_o}, 0);
  endtask

  initial begin
    resetn = 1'b0; op_valid_i = 0; op_type_i = 0; flush_i = 0; cp0_index_i = 0;
    dtlb_req_i = 0; tlb_match_i = 0; tlb_match_idx_i = 0;
    tick(); tick();
    chk_quiet("reset");
    resetn = 1'b1;
    #1 chk("rand_release", {28'b0, random_o}, 15);
    for (int i = 0; i < 17; i++) tick();

    // TLBP hit at index 5; op_valid drop mid-op must be ignored
    op_valid_i = 1; op_type_i = 2'b00;
    #1 chk("p_acc_stall", {31'b0, stall_o}, 1);
    chk("p_acc_search", {31'b0, tlb_search_o}, 0);
    tick();
    chk("p_search", {31'b0, tlb_search_o}, 1);
    chk("p_search_stall", {31'b0, stall_o}, 1);
    op_valid_i = 0; tlb_match_i = 1; tlb_match_idx_i = 4'd5;
    tick();
    tlb_match_i = 0; tlb_match_idx_i = 0;
    #1 chk("p_done", {31'b0, op_done_o}, 1);
    chk("p_done_stall", {31'b0, stall_o}, 0);
    chk("p_type", {30'b0, tlb_type_o}, 2);
    chk("p_wdata", index_wdata_o, 32'h0000_0005);
    tick();
    chk_quiet("p_idle");

    // TLBP miss with data side requesting throughout
    dtlb_req_i = 1;
    #1 chk("m_gnt_idle", {31'b0, dtlb_gnt_o}, 1);
    op_valid_i = 1; op_type_i = 2'b00;
    #1 chk("m_gnt_acc", {31'b0, dtlb_gnt_o}, 1);
    tick();
    op_valid_i = 0;
    #1 chk("m_gnt_search", {31'b0, dtlb_gnt_o}, 0);
    chk("m_search", {31'b0, tlb_search_o}, 1);
    tick();
    chk("m_gnt_done", {31'b0, dtlb_gnt_o}, 1);
    chk("m_type", {30'b0, tlb_type_o}, 2);
    chk("m_wdata", index_wdata_o, 32'h8000_0000);
    tick();
    chk("m_gnt_after", {31'b0, dtlb_gnt_o}, 1);
    dtlb_req_i = 0;

    // TLBWI to index 7
    op_valid_i = 1; op_type_i = 2'b10; cp0_index_i = 32'hFFFF_FFF7;
    #1 chk("wi_acc_we", {31'b0, tlb_we_o}, 0);
    tick();
    op_valid_i = 0; cp0_index_i = 0;
    #1 chk("wi_we", {31'b0, tlb_we_o}, 1);
    chk("wi_widx", {28'b0, tlb_widx_o}, 7);
    chk("wi_gnt", {31'b0, dtlb_gnt_o}, 0);
    tick();
    chk("wi_done", {31'b0, op_done_o}, 1);
    chk("wi_done_we", {31'b0, tlb_we_o}, 0);
    chk("wi_type", {30'b0, tlb_type_o}, 0);
    tick();
    chk_quiet("wi_idle");

    // TLBWR accepted while Random reads 3
    for (int i = 0; i < 20 && exp_rand != 3; i++) tick();
    chk("wr_rand", {28'b0, random_o}, 3);
    op_valid_i = 1; op_type_i = 2'b11; cp0_index_i = 32'd7;
    tick();
    op_valid_i = 0;
    #1 chk("wr_we", {31'b0, tlb_we_o}, 1);
    chk("wr_widx", {28'b0, tlb_widx_o}, 3);
    tick();
    chk("wr_done", {31'b0, op_done_o}, 1);
    chk("wr_type", {30'b0, tlb_type_o}, 0);
    tick();

    // TLBR index 9
    op_valid_i = 1; op_type_i = 2'b01; cp0_index_i = 32'd9;
    tick();
    op_valid_i = 0; cp0_index_i = 0;
    #1 chk("r_ridx", {28'b0, tlb_ridx_o}, 9);
    chk("r_type_read", {30'b0, tlb_type_o}, 0);
    chk("r_we", {31'b0, tlb_we_o}, 0);
    tick();
    chk("r_done_ridx", {28'b0, tlb_ridx_o}, 9);
    chk("r_type", {30'b0, tlb_type_o}, 1);
    chk("r_done", {31'b0, op_done_o}, 1);
    tick();
    chk_quiet("r_idle");

    // Flush during WRITE aborts the op
    op_valid_i = 1; op_type_i = 2'b10; cp0_index_i = 32'd4;
    tick();
    op_valid_i = 0; flush_i = 1;
    #1 chk("fw_we", {31'b0, tlb_we_o}, 0);
    chk("fw_stall", {31'b0, stall_o}, 1);
    tick();
    flush_i = 0;
    #1 chk_quiet("fw_idle");
    tick();
    chk("fw_nodone", {31'b0, op_done_o}, 0);

    // Flush in IDLE blocks accept
    op_valid_i = 1; op_type_i = 2'b00; flush_i = 1;
    #1 chk("fi_stall", {31'b0, stall_o}, 0);
    tick();
    op_valid_i = 0; flush_i = 0;
    #1 chk("fi_search", {31'b0, tlb_search_o}, 0);

    // Flush in DONE still writes back
    op_valid_i = 1; op_type_i = 2'b01; cp0_index_i = 32'd2;
    tick();
    op_valid_i = 0;
    tick();
    flush_i = 1;
    #1 chk("fd_type", {30'b0, tlb_type_o}, 1);
    chk("fd_done", {31'b0, op_done_o}, 1);
    tick();
    flush_i = 0;
`ifdef TLB_OP_PERF_CNT_EN
    chk("perf_ops", perf_ops_o, 6);
    chk("perf_miss", perf_miss_o, 1);
`endif

    // Reset mid-SEARCH clears everything at once
    op_valid_i = 1; op_type_i = 2'b00;
    tick();
    op_valid_i = 0;
    #1 chk("rs_search", {31'b0, tlb_search_o}, 1);
    resetn = 0; exp_rand = 15;
    #1 chk_quiet("rs_async");
    chk("rs_rand", {28'b0, random_o}, 15);
    tick();
    resetn = 1;
    tick();
    chk_quiet("rs_idle");
`ifdef TLB_OP_PERF_CNT_EN
    chk("perf_ops_rst", perf_ops_o, 0);
    chk("perf_miss_rst", perf_miss_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
